// File: rtl/mem_spy_arb.sv
// mem_spy_arb: round-robin arbiter turning remote memory accesses into 2-beat NoC packets, blocking the port until unblock or timeout
module mem_spy_arb #(
  parameter int NUM_CH    = 2,
  parameter int XY_SZ     = 3,
  parameter int OFFSET_SZ = 12,
  parameter int TIMEOUT   = 4096,
  parameter int ERRCNT_W  = 8
) (
  input  logic                   clk_ctrl,
  input  logic                   clk_ctrl_rst_high,
  input  logic [2*XY_SZ-1:0]     HsrcId,
  input  logic [NUM_CH-1:0]      mem_valid,
  input  logic [NUM_CH*32-1:0]   mem_addr,
  input  logic [NUM_CH*32-1:0]   mem_wdata,
  input  logic [NUM_CH*4-1:0]    mem_wstrb,
  input  logic [NUM_CH-1:0]      local_mem,
  output logic [NUM_CH-1:0]      mem_ready,
  output logic [NUM_CH-1:0]      mem_err,
  input  logic                   unblock,
  output logic                   spy_idle,
  output logic [ERRCNT_W-1:0]    err_cnt,
  input  logic                   stream_out_TREADY,
  output logic                   stream_out_TVALID,
  output logic [31:0]            stream_out_TDATA,
  output logic [3:0]             stream_out_TKEEP,
  output logic                   stream_out_TLAST
);
  localparam int GW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, HDR, PAY, WAIT} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] rr_q, rr_d, gnt_q, gnt_d, sel;
  logic [TW-1:0] timer_q, timer_d;
  logic [ERRCNT_W-1:0] errc_q, errc_d;
  logic [NUM_CH-1:0] rdy_q, rdy_d, err_q, err_d, elig;
  logic [31:0] hdr_q, hdr_d, pay_q, pay_d, a;
  logic [3:0] keep_q, keep_d, s;
  logic any, tmo;
  logic unused_addr;
  assign unused_addr = ^mem_addr;
  always_comb begin
    elig = mem_valid & ~local_mem & ~rdy_q;
    sel = '0;
    any = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (elig[(int'(rr_q) + k) % NUM_CH]) begin
        sel = GW'((int'(rr_q) + k) % NUM_CH);
        any = 1'b1;
      end
    a = mem_addr[32*int'(sel) +: 32];
    s = mem_wstrb[4*int'(sel) +: 4];
    tmo = TIMEOUT != 0 && timer_q == TW'(TIMEOUT - 1);
    state_d = state_q;
    rr_d = rr_q;
    gnt_d = gnt_q;
    hdr_d = hdr_q;
    pay_d = pay_q;
    keep_d = keep_q;
    timer_d = state_q == WAIT ? timer_q + 1'b1 : '0;
    rdy_d = '0;
    err_d = '0;
    errc_d = errc_q;
    case (state_q)
      IDLE: if (any) begin
        state_d = HDR;
        gnt_d = sel;
        rr_d = int'(sel) == NUM_CH - 1 ? '0 : sel + 1'b1;
        hdr_d = 32'({1'b0, |s ? 3'd7 : 3'd6, |s && s != 4'hF, HsrcId, a[OFFSET_SZ-1:0],
                     a[OFFSET_SZ+XY_SZ +: XY_SZ], a[OFFSET_SZ +: XY_SZ]});
        pay_d = |s ? mem_wdata[32*int'(sel) +: 32] : '0;
        keep_d = |s ? s : 4'hF;
      end
      HDR: state_d = stream_out_TREADY ? PAY : HDR;
      PAY: state_d = stream_out_TREADY ? WAIT : PAY;
      WAIT: if (unblock || tmo) begin
        // unblock takes priority over a timeout landing on the same cycle
        state_d = IDLE;
        rdy_d[gnt_q] = 1'b1;
        err_d[gnt_q] = ~unblock;
        errc_d = unblock || &errc_q ? errc_q : errc_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_ctrl) begin
    if (clk_ctrl_rst_high) begin
      state_q <= IDLE;
      rr_q <= '0;
      gnt_q <= '0;
      timer_q <= '0;
      errc_q <= '0;
      rdy_q <= '0;
      err_q <= '0;
      hdr_q <= '0;
      pay_q <= '0;
      keep_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      gnt_q <= gnt_d;
      timer_q <= timer_d;
      errc_q <= errc_d;
      rdy_q <= rdy_d;
      err_q <= err_d;
      hdr_q <= hdr_d;
      pay_q <= pay_d;
      keep_q <= keep_d;
    end
  end
  assign mem_ready = rdy_q;
  assign mem_err = err_q;
  assign err_cnt = errc_q;
  assign spy_idle = state_q == IDLE;
  assign stream_out_TVALID = state_q == HDR || state_q == PAY;
  assign stream_out_TLAST = state_q == PAY;
  assign stream_out_TDATA = state_q == HDR ? hdr_q : state_q == PAY ? pay_q : '0;
  assign stream_out_TKEEP = state_q == HDR ? 4'hF : state_q == PAY ? keep_q : '0;
endmodule

// File: tb/tb_mem_spy_arb.sv
// tb_mem_spy_arb: randomized self-checking bench for mem_spy_arb against a transaction-level model
module tb_mem_spy_arb;
  localparam int NC = 3;
  localparam int TO = 16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [5:0] HsrcId;
  logic [NC-1:0] mem_valid, local_mem, mem_ready, mem_err;
  logic [NC*32-1:0] mem_addr, mem_wdata;
  logic [NC*4-1:0] mem_wstrb;
  logic unblock, spy_idle, tready, tvalid, tlast;
  logic [7:0] err_cnt;
  logic [31:0] tdata;
  logic [3:0] tkeep;
  int n_vec = 0, n_err = 0, ref_rr = 0, exp_err = 0;
  logic [NC-1:0] rdy_mask = '0;

  mem_spy_arb #(.NUM_CH(NC), .XY_SZ(3), .OFFSET_SZ(12), .TIMEOUT(TO), .ERRCNT_W(8)) dut (
    .clk_ctrl(clk), .clk_ctrl_rst_high(rst), .HsrcId(HsrcId),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .local_mem(local_mem), .mem_ready(mem_ready), .mem_err(mem_err), .unblock(unblock),
    .spy_idle(spy_idle), .err_cnt(err_cnt), .stream_out_TREADY(tready),
    .stream_out_TVALID(tvalid), .stream_out_TDATA(tdata), .stream_out_TKEEP(tkeep),
    .stream_out_TLAST(tlast));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(logic [NC-1:0] el);
    for (int k = 0; k < NC; k++)
      if (el[(ref_rr + k) % NC]) return (ref_rr + k) % NC;
    return -1;
  endfunction

  function automatic logic [31:0] exp_hdr(logic [31:0] a, logic [3:0] s, logic [5:0] src);
    int unsigned x, y, off, code, pt, id;
    x = (a / 4096) % 8;
    y = (a / 32768) % 8;
    off = a % 4096;
    id = src;
    code = s != 0 ? 7 : 6;
    pt = (s != 0 && s != 4'hF) ? 1 : 0;
    return x + y * 8 + off * 64 + id * 262144 + pt * 16777216 + code * 33554432;
  endfunction

  task automatic set_port(int c, bit v, bit l, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    mem_valid[c] = v;
    local_mem[c] = l;
    mem_addr[32*c +: 32] = a;
    mem_wdata[32*c +: 32] = d;
    mem_wstrb[4*c +: 4] = s;
  endtask

  task automatic serve(input int stall, input int ubd, output int g);
    logic [31:0] h, d;
    logic [3:0] s, k;
    logic [NC-1:0] want;
    g = -1;
    h = '0;
    d = '0;
    k = '0;
    tready = 1'b0;
    for (int t = 0; t < 6 && g < 0; t++) begin
      g = pick(mem_valid & ~local_mem & ~rdy_mask);
      if (g >= 0) begin
        s = mem_wstrb[4*g +: 4];
        h = exp_hdr(mem_addr[32*g +: 32], s, HsrcId);
        d = s != 0 ? mem_wdata[32*g +: 32] : 32'h0;
        k = s != 0 ? s : 4'hF;
      end
      tick;
      rdy_mask = '0;
      n_vec++;
      if (mem_ready !== '0 || tvalid !== (g >= 0)) begin
        n_err++;
        $display("FAIL grant: ready=%b tvalid=%b, want ready=0 tvalid=%0d", mem_ready, tvalid, g >= 0);
      end
    end
    if (g < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL grant_wait: no grant within 6 cycles, want one");
      return;
    end
    ref_rr = (g + 1) % NC;
    for (int t = 0; t <= stall; t++) begin
      n_vec++;
      if ({tvalid, tdata, tkeep, tlast, spy_idle} !== {1'b1, h, 4'hF, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL header: v=%b d=%h k=%h l=%b idle=%b, want v=1 d=%h k=f l=0 idle=0", tvalid, tdata, tkeep, tlast, spy_idle, h);
      end
      if (t == stall) tready = 1'b1;
      tick;
      tready = 1'b0;
    end
    for (int t = 0; t <= stall; t++) begin
      n_vec++;
      if ({tvalid, tdata, tkeep, tlast} !== {1'b1, d, k, 1'b1}) begin
        n_err++;
        $display("FAIL payload: v=%b d=%h k=%h l=%b, want v=1 d=%h k=%h l=1", tvalid, tdata, tkeep, tlast, d, k);
      end
      if (t == stall) tready = 1'b1;
      tick;
      tready = 1'b0;
    end
    n_vec++;
    if (tvalid !== 1'b0 || spy_idle !== 1'b0) begin
      n_err++;
      $display("FAIL wait_entry: tvalid=%b idle=%b, want 0 0", tvalid, spy_idle);
    end
    want = NC'(1 << g);
    if (ubd >= 0) begin
      repeat (ubd) begin
        tick;
        n_vec++;
        if (mem_ready !== '0 || tvalid !== 1'b0) begin
          n_err++;
          $display("FAIL wait_hold: ready=%b tvalid=%b, want 0 0", mem_ready, tvalid);
        end
      end
      unblock = 1'b1;
      tick;
      unblock = 1'b0;
      n_vec++;
      if (mem_ready !== want || mem_err !== '0) begin
        n_err++;
        $display("FAIL unblock_done: ready=%b err=%b, want ready=%b err=0", mem_ready, mem_err, want);
      end
    end else begin
      for (int t = 1; t <= TO; t++) begin
        tick;
        if (t < TO) begin
          n_vec++;
          if (mem_ready !== '0) begin
            n_err++;
            $display("FAIL early_timeout: ready=%b at wait cycle %0d, want 0", mem_ready, t);
          end
        end
      end
      exp_err = exp_err < 255 ? exp_err + 1 : 255;
      n_vec++;
      if (mem_ready !== want || mem_err !== want) begin
        n_err++;
        $display("FAIL timeout_done: ready=%b err=%b, want both %b", mem_ready, mem_err, want);
      end
    end
    n_vec++;
    if (err_cnt !== exp_err[7:0] || spy_idle !== 1'b1) begin
      n_err++;
      $display("FAIL done_state: err_cnt=%0d idle=%b, want err_cnt=%0d idle=1", err_cnt, spy_idle, exp_err);
    end
    rdy_mask = want;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_vec++;
    if ({tvalid, tdata, tkeep, tlast, spy_idle, mem_ready, mem_err, err_cnt} !== {1'b1 ^ 1'b1, 32'h0, 4'h0, 1'b0, 1'b1, {NC{1'b0}}, {NC{1'b0}}, 8'h0}) begin
      n_err++;
      $display("FAIL reset: v=%b d=%h k=%h l=%b idle=%b rdy=%b err=%b cnt=%0d, want all 0 except idle=1", tvalid, tdata, tkeep, tlast, spy_idle, mem_ready, mem_err, err_cnt);
    end
    rst = 1'b0;
    ref_rr = 0;
    exp_err = 0;
    rdy_mask = '0;
  endtask

  task automatic test_load;
    int g;
    HsrcId = 6'o12;
    set_port(0, 1'b1, 1'b0, 32'h0000_9ABC, 32'h1234_5678, 4'h0);
    serve(0, 5, g);
    mem_valid = '0;
  endtask

  task automatic test_store_stall;
    int g;
    set_port(1, 1'b1, 1'b0, $urandom, 32'hDEAD_BEEF, 4'h3);
    serve(3, 2, g);
    mem_valid = '0;
  endtask

  task automatic test_rr;
    int g;
    set_port(0, 1'b1, 1'b0, $urandom, $urandom, 4'hF);
    set_port(1, 1'b1, 1'b0, $urandom, $urandom, 4'h0);
    set_port(2, 1'b1, 1'b1, $urandom, $urandom, 4'h5);
    repeat (8) begin
      serve(0, 2, g);
      if (g >= 0) set_port(g, 1'b1, 1'b0, $urandom, $urandom, 4'($urandom));
    end
    mem_valid = '0;
    local_mem = '0;
  endtask

  task automatic test_random;
    int g, c;
    logic [3:0] s;
    repeat (40) begin
      HsrcId = 6'($urandom);
      for (int i = 0; i < NC; i++) begin
        s = $urandom_range(0, 2) == 0 ? 4'h0 : $urandom_range(0, 1) == 0 ? 4'hF : 4'($urandom);
        set_port(i, 1'($urandom), 1'($urandom_range(0, 3) == 0), $urandom, $urandom, s);
      end
      c = $urandom_range(0, NC - 1);
      if (rdy_mask[c]) c = (c + 1) % NC;
      mem_valid[c] = 1'b1;
      local_mem[c] = 1'b0;
      serve($urandom_range(0, 3), $urandom_range(0, 6), g);
    end
    mem_valid = '0;
    local_mem = '0;
  endtask

  task automatic test_timeout;
    int g;
    set_port(0, 1'b1, 1'b0, $urandom, $urandom, 4'h0);
    serve(0, -1, g);
    serve(1, TO - 1, g);
  endtask

  task automatic test_saturate;
    int g;
    repeat (299) serve(0, -1, g);
    n_vec++;
    if (err_cnt !== 8'hFF) begin
      n_err++;
      $display("FAIL saturate: err_cnt=%0d, want 255", err_cnt);
    end
    mem_valid = '0;
  endtask

  task automatic test_reset_mid;
    int g;
    set_port(0, 1'b1, 1'b0, $urandom, 32'hCAFE_F00D, 4'hF);
    tready = 1'b0;
    for (int t = 0; t < 4 && tvalid !== 1'b1; t++) tick;
    tready = 1'b1;
    tick;
    tready = 1'b0;
    tick;
    n_vec++;
    if (tvalid !== 1'b1 || tlast !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pay: tvalid=%b tlast=%b, want 1 1", tvalid, tlast);
    end
    rst = 1'b1;
    tick;
    n_vec++;
    if ({tvalid, tdata, spy_idle, mem_ready, err_cnt} !== {1'b0, 32'h0, 1'b1, {NC{1'b0}}, 8'h0}) begin
      n_err++;
      $display("FAIL mid_reset: v=%b d=%h idle=%b rdy=%b cnt=%0d, want v=0 d=0 idle=1 rdy=0 cnt=0", tvalid, tdata, spy_idle, mem_ready, err_cnt);
    end
    rst = 1'b0;
    mem_valid = '0;
    ref_rr = 0;
    exp_err = 0;
    rdy_mask = '0;
    repeat (2) begin
      tick;
      n_vec++;
      if (tvalid !== 1'b0 || mem_ready !== '0) begin
        n_err++;
        $display("FAIL post_reset: tvalid=%b ready=%b, want 0 0", tvalid, mem_ready);
      end
    end
    unblock = 1'b1;
    tick;
    unblock = 1'b0;
    tick;
    n_vec++;
    if (mem_ready !== '0 || spy_idle !== 1'b1) begin
      n_err++;
      $display("FAIL idle_unblock: ready=%b idle=%b, want 0 1", mem_ready, spy_idle);
    end
    set_port(1, 1'b1, 1'b0, $urandom, $urandom, 4'h6);
    serve(0, TO - 1, g);
    mem_valid = '0;
  endtask

  initial begin
    rst = 1'b1;
    HsrcId = '0;
    mem_valid = '0;
    local_mem = '0;
    mem_addr = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    unblock = 1'b0;
    tready = 1'b0;
    test_reset;
    test_load;
    test_store_stall;
    test_rr;
    test_random;
    test_timeout;
    test_saturate;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
